// File: rtl/ir_key_decoder.sv
// Turns the level-held 32-bit NEC word into debounced single-cycle key events,
// and keeps the snake heading (with reversal rejection) and the difficulty level.
module ir_key_decoder #(
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [31:0] word,
  input  logic        game_enable,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [1:0]  dir,
  output logic [2:0]  difficulty
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [3:0] KEY_NONE  = 4'd0;
  localparam logic [3:0] KEY_UP    = 4'd1;
  localparam logic [3:0] KEY_DOWN  = 4'd2;
  localparam logic [3:0] KEY_LEFT  = 4'd3;
  localparam logic [3:0] KEY_RIGHT = 4'd4;
  localparam logic [3:0] KEY_ENTER = 4'd5;
  localparam logic [3:0] KEY_MENU  = 4'd6;
  localparam logic [3:0] KEY_ONE   = 4'd7;
  localparam logic [3:0] KEY_TWO   = 4'd8;
  localparam logic [3:0] KEY_THREE = 4'd9;
  localparam logic [3:0] KEY_FOUR  = 4'd10;
  localparam logic [3:0] KEY_FIVE  = 4'd11;
  localparam logic [3:0] KEY_SIX   = 4'd12;
  localparam logic [3:0] KEY_OTHER = 4'd15;

  localparam logic [1:0] HEAD_UP    = 2'd0;
  localparam logic [1:0] HEAD_RIGHT = 2'd1;
  localparam logic [1:0] HEAD_DOWN  = 2'd2;
  localparam logic [1:0] HEAD_LEFT  = 2'd3;

  localparam logic [2:0] DIFF_RESET = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_EMIT
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      meta_q, meta_d;
  logic [31:0]      sync_q, sync_d;
  logic [31:0]      last_word_q, last_word_d;
  logic [31:0]      cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [1:0]       dir_q, dir_d;
  logic [2:0]       difficulty_q, difficulty_d;

  logic [3:0]       cand_key;
  logic [1:0]       cand_head;

  // NEC word to key enumeration; ONE is recognised by its low half only.
  function automatic logic [3:0] decode_word(input logic [31:0] w);
    logic [3:0] k;
    case (w)
      32'h20DF6A95: k = KEY_UP;
      32'h20DFEA15: k = KEY_DOWN;
      32'h20DF1AE5: k = KEY_LEFT;
      32'h20DF9A65: k = KEY_RIGHT;
      32'h20DF5AA5: k = KEY_ENTER;
      32'h20DFC23D: k = KEY_MENU;
      32'h20DF48B7: k = KEY_TWO;
      32'h20DFC837: k = KEY_THREE;
      32'h20DF28D7: k = KEY_FOUR;
      32'h20DFA857: k = KEY_FIVE;
      32'h20DF6897: k = KEY_SIX;
      default: begin
        if (w[15:0] == 16'h8877) begin
          k = KEY_ONE;
        end else if (w != 32'h0) begin
          k = KEY_OTHER;
        end else begin
          k = KEY_NONE;
        end
      end
    endcase
    return k;
  endfunction

  function automatic logic [1:0] key_heading(input logic [3:0] k);
    logic [1:0] h;
    case (k)
      KEY_UP:    h = HEAD_UP;
      KEY_RIGHT: h = HEAD_RIGHT;
      KEY_DOWN:  h = HEAD_DOWN;
      KEY_LEFT:  h = HEAD_LEFT;
      default:   h = HEAD_RIGHT;
    endcase
    return h;
  endfunction

  assign cand_key  = decode_word(cand_q);
  assign cand_head = key_heading(cand_key);

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    meta_d       = word;
    sync_d       = meta_q;
    last_word_d  = last_word_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    key_valid_d  = 1'b0;
    key_code_d   = key_code_q;
    dir_d        = dir_q;
    difficulty_d = difficulty_q;

    case (state_q)
      ST_IDLE: begin
        if ((sync_q != last_word_q) && (sync_q != 32'h0)) begin
          cand_d  = sync_q;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (sync_q == last_word_q) begin
          state_d = ST_IDLE;
        end else if (sync_q != cand_q) begin
          cand_d = sync_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          // A zero word that settled is dropped silently.
          if (cand_q == 32'h0) begin
            state_d = ST_IDLE;
          end else begin
            state_d     = ST_EMIT;
            key_valid_d = 1'b1;
            key_code_d  = cand_key;
            if (game_enable) begin
              if ((cand_key >= KEY_UP) && (cand_key <= KEY_RIGHT) &&
                  (cand_head != (dir_q ^ 2'd2))) begin
                dir_d = cand_head;
              end
            end else if ((cand_key >= KEY_ONE) && (cand_key <= KEY_SIX)) begin
              difficulty_d = 3'(cand_key - KEY_MENU);
            end
          end
        end else begin
          cnt_d = CNT_W'(cnt_q + 1'b1);
        end
      end

      ST_EMIT: begin
        last_word_d = cand_q;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outside the game the snake always faces right.
    if (!game_enable) begin
      dir_d = HEAD_RIGHT;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      meta_q       <= '0;
      sync_q       <= '0;
      last_word_q  <= '0;
      cand_q       <= '0;
      cnt_q        <= '0;
      key_valid_q  <= 1'b0;
      key_code_q   <= KEY_NONE;
      dir_q        <= HEAD_RIGHT;
      difficulty_q <= DIFF_RESET;
    end else begin
      state_q      <= state_d;
      meta_q       <= meta_d;
      sync_q       <= sync_d;
      last_word_q  <= last_word_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      dir_q        <= dir_d;
      difficulty_q <= difficulty_d;
    end
  end

  assign key_valid  = key_valid_q;
  assign key_code   = key_code_q;
  assign dir        = dir_q;
  assign difficulty = difficulty_q;

endmodule

// File: tb/tb_ir_key_decoder.sv
// Bench for ir_key_decoder: directed then random word segments, checked cycle by
// cycle against a segment-level reference model.
module tb_ir_key_decoder;

  localparam int unsigned S    = 4;
  localparam int          MAXE = 8192;

  localparam logic [31:0] W_UP    = 32'h20DF6A95;
  localparam logic [31:0] W_DOWN  = 32'h20DFEA15;
  localparam logic [31:0] W_LEFT  = 32'h20DF1AE5;
  localparam logic [31:0] W_ENTER = 32'h20DF5AA5;
  localparam logic [31:0] W_MENU  = 32'h20DFC23D;
  localparam logic [31:0] W_FOUR  = 32'h20DF28D7;
  localparam logic [31:0] W_FIVE  = 32'h20DFA857;
  localparam logic [31:0] W_SIX   = 32'h20DF6897;

  localparam logic [31:0] CODE_TBL [11] = '{
    32'h20DF6A95, 32'h20DFEA15, 32'h20DF1AE5, 32'h20DF9A65, 32'h20DF5AA5, 32'h20DFC23D,
    32'h20DF48B7, 32'h20DFC837, 32'h20DF28D7, 32'h20DFA857, 32'h20DF6897};
  localparam int KEY_TBL [11] = '{1, 2, 3, 4, 5, 6, 8, 9, 10, 11, 12};

  logic        clk;
  logic        reset;
  logic [31:0] word;
  logic        game_enable;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [1:0]  dir;
  logic [2:0]  difficulty;

  ir_key_decoder #(.STABLE_CYCLES(S)) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .word        (word),
    .game_enable (game_enable),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .dir         (dir),
    .difficulty  (difficulty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int ref_code(input logic [31:0] w);
    for (int i = 0; i < 11; i++) if (CODE_TBL[i] == w) return KEY_TBL[i];
    if (w[15:0] == 16'h8877) return 7;
    if (w != 32'h0) return 15;
    return 0;
  endfunction

  // Heading for a direction key, -1 for any other key.
  function automatic int ref_heading(input int k);
    case (k)
      1: return 0;
      4: return 1;
      2: return 2;
      3: return 3;
      default: return -1;
    endcase
  endfunction

  logic [31:0] seg_word [$];
  int          seg_len  [$];
  bit          seg_ge   [$];

  logic [31:0] in_word   [MAXE];
  bit          in_ge     [MAXE];
  bit          pulse     [MAXE];
  int          pcode     [MAXE];
  int          exp_code  [MAXE];
  int          exp_dir   [MAXE];
  int          exp_diff  [MAXE];

  task automatic add_seg(input logic [31:0] w, input int len, input bit ge);
    seg_word.push_back(w);
    seg_len.push_back(len);
    seg_ge.push_back(ge);
  endtask

  initial begin
    int          nedge;
    int          start;
    logic [31:0] last;
    logic [31:0] prev;
    logic [31:0] w;
    int          len;
    int          r;
    int          d;
    int          df;
    int          kc;
    int          hd;

    reset = 1'b1;
    word = 32'h0;
    game_enable = 1'b0;

    // Directed scenarios.
    add_seg(W_ENTER, 20, 1'b0);
    add_seg(W_FOUR, 20, 1'b0);
    add_seg(32'h12348877, 20, 1'b0);
    add_seg(W_FIVE, 20, 1'b1);
    add_seg(W_UP, 20, 1'b1);
    add_seg(W_DOWN, 20, 1'b1);
    add_seg(W_LEFT, 20, 1'b1);
    add_seg(W_LEFT, 10, 1'b0);
    add_seg(W_ENTER, 20, 1'b0);
    add_seg(W_MENU, 2, 1'b0);
    add_seg(W_ENTER, 20, 1'b0);
    add_seg(W_MENU, 2, 1'b0);
    add_seg(W_SIX, 20, 1'b0);
    add_seg(32'h12345678, 20, 1'b0);
    add_seg(32'h0, 20, 1'b0);

    // Random segments: long holds or short glitches, each word differs from the previous.
    prev = 32'h0;
    for (int i = 0; i < 45; i++) begin
      bit glitch;
      glitch = ($urandom_range(0, 9) < 3);
      len = glitch ? int'($urandom_range(1, S)) : int'($urandom_range(S + 6, S + 15));
      do begin
        r = int'($urandom_range(0, 15));
        if (r <= 10) w = CODE_TBL[r];
        else if (r == 11) w = {16'($urandom), 16'h8877};
        else if (r == 12) w = 32'h0;
        else w = $urandom;
      end while (w == prev);
      prev = w;
      add_seg(w, len, 1'($urandom_range(0, 1)));
    end

    // Expand segments into per-edge stimulus and predicted pulses.
    nedge = 0;
    last = 32'h0;
    for (int i = 0; i < MAXE; i++) begin
      pulse[i] = 1'b0;
      pcode[i] = 0;
    end
    for (int s = 0; s < seg_word.size(); s++) begin
      start = nedge + 1;
      for (int k = 0; k < seg_len[s]; k++) begin
        nedge++;
        in_word[nedge] = seg_word[s];
        in_ge[nedge] = seg_ge[s];
      end
      // A new nonzero code held for S+1 samples pulses S+2 edges after its first sample.
      if (seg_word[s] != last && seg_word[s] != 32'h0 && seg_len[s] >= int'(S) + 1) begin
        pulse[start + int'(S) + 2] = 1'b1;
        pcode[start + int'(S) + 2] = ref_code(seg_word[s]);
        last = seg_word[s];
      end
    end

    d = 1; df = 4; kc = 0;
    for (int n = 1; n <= nedge; n++) begin
      if (pulse[n]) begin
        kc = pcode[n];
        if (in_ge[n]) begin
          hd = ref_heading(kc);
          if (hd >= 0 && hd != (d + 2) % 4) d = hd;
        end else if (kc >= 7 && kc <= 12) begin
          df = kc - 6;
        end
      end
      if (!in_ge[n]) d = 1;
      exp_code[n] = kc;
      exp_dir[n]  = d;
      exp_diff[n] = df;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_kv", 32'(key_valid), 32'd0);
    check_val("rst_code", 32'(key_code), 32'd0);
    check_val("rst_dir", 32'(dir), 32'd1);
    check_val("rst_diff", 32'(difficulty), 32'd4);
    @(negedge clk);
    reset = 1'b0;

    for (int n = 1; n <= nedge; n++) begin
      word = in_word[n];
      game_enable = in_ge[n];
      @(posedge clk);
      #1;
      check_val($sformatf("kv@%0d", n), 32'(key_valid), 32'(pulse[n]));
      check_val($sformatf("code@%0d", n), 32'(key_code), 32'(exp_code[n]));
      check_val($sformatf("dir@%0d", n), 32'(dir), 32'(exp_dir[n]));
      check_val($sformatf("diff@%0d", n), 32'(difficulty), 32'(exp_diff[n]));
      @(negedge clk);
    end

    // Reset in the middle of settling MENU, then re-emit after release.
    game_enable = 1'b0;
    word = W_MENU;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("mid_kv@%0d", n), 32'(key_valid), 32'd0);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_val("mid_rst_kv", 32'(key_valid), 32'd0);
    check_val("mid_rst_code", 32'(key_code), 32'd0);
    check_val("mid_rst_dir", 32'(dir), 32'd1);
    check_val("mid_rst_diff", 32'(difficulty), 32'd4);
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      check_val($sformatf("rel_kv@%0d", n), 32'(key_valid), (n == 7) ? 32'd1 : 32'd0);
      check_val($sformatf("rel_code@%0d", n), 32'(key_code), (n >= 7) ? 32'd6 : 32'd0);
      check_val($sformatf("rel_diff@%0d", n), 32'(difficulty), 32'd4);
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
